alu_issue_ctrl: RTL

//  Initiator side of the ALU operand/result interface. Accepts one operation from decode
//  (valid/ready), drives the registered ALU's operands and opcode, and waits the ALU's

---
 rtl/alu_issue_ctrl_if.sv | 43 ++++
 rtl/alu_issue_ctrl.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl_if.sv
// alu_issue_ctrl_if
//   Bundles the three buses around the ALU issue controller:
//     req_* : decode -> controller op request (valid/ready)
//     alu_* : controller <-> registered ALU (operands/opcode out, result/Zero in)
//     rsp_* : controller -> writeback/branch response (valid/ready)
//   master : the controller side (drives req_ready, alu operands, response)
//   slave  : the surrounding pipeline and ALU (drive requests, ALU outputs, rsp_ready)
interface alu_issue_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int OP_W   = 3,
  parameter int TAG_W  = 3
);
  logic              req_valid;
  logic              req_ready;
  logic [DATA_W-1:0] req_a;
  logic [DATA_W-1:0] req_b;
  logic [OP_W-1:0]   req_op;
  logic [TAG_W-1:0]  req_tag;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [OP_W-1:0]   alu_op;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_zero;
  logic [TAG_W-1:0]  rsp_tag;

  modport master (
    input  req_valid, req_a, req_b, req_op, req_tag,
    input  alu_result, alu_zero, rsp_ready,
    output req_ready, alu_a, alu_b, alu_op,
    output rsp_valid, rsp_data, rsp_zero, rsp_tag
  );

  modport slave (
    output req_valid, req_a, req_b, req_op, req_tag,
    output alu_result, alu_zero, rsp_ready,
    input  req_ready, alu_a, alu_b, alu_op,
    input  rsp_valid, rsp_data, rsp_zero, rsp_tag
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
//   Issues one op at a time to a clocked ALU: accepts an op from decode, holds the
//   operands/opcode on registered outputs, waits the ALU latency, captures result and
//   Zero flag and holds them for writeback until taken. One op in flight.
// Ports
//   CLK    : clock, rising edge
//   Reset  : synchronous active-high reset, highest priority
//   flush  : squash any in-flight or held op; blocks accepts while high
//   busy   : high while an op is waiting on the ALU or its response is held
//   bus    : alu_issue_ctrl_if.master (req_*, alu_*, rsp_* groups)
module alu_issue_ctrl #(
  parameter int DATA_W  = 16,
  parameter int OP_W    = 3,
  parameter int TAG_W   = 3,
  parameter int ALU_LAT = 1
) (
  input  logic CLK,
  input  logic Reset,
  input  logic flush,
  output logic busy,
  alu_issue_ctrl_if.master bus
);

  localparam int CNT_W = (ALU_LAT > 0) ? $clog2(ALU_LAT + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t            state_r;
  state_t            next_state_s;
  state_t            fsm_next_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [TAG_W-1:0]  tag_r;
  logic [DATA_W-1:0] alu_a_r;
  logic [DATA_W-1:0] alu_b_r;
  logic [OP_W-1:0]   alu_op_r;
  logic [DATA_W-1:0] rsp_data_r;
  logic              rsp_zero_r;
  logic [TAG_W-1:0]  rsp_tag_r;
  logic              req_ready_s;
  logic              accept_s;
  logic              capture_s;

  // Handshake and next-state decode; flush overrides the normal transition.
  always_comb begin
    req_ready_s  = 1'b0;
    accept_s     = 1'b0;
    capture_s    = 1'b0;
    fsm_next_s   = state_r;
    next_state_s = state_r;

    // A held response may be replaced on the same edge it is consumed.
    if (!Reset && !flush) begin
      req_ready_s = (state_r == ST_IDLE) || ((state_r == ST_RESP) && bus.rsp_ready);
    end else begin
      req_ready_s = 1'b0;
    end
    accept_s  = bus.req_valid && req_ready_s;
    capture_s = (state_r == ST_WAIT) && (cnt_r == CNT_W'(0)) && !flush;

    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          fsm_next_s = ST_WAIT;
        end else begin
          fsm_next_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r == CNT_W'(0)) begin
          fsm_next_s = ST_RESP;
        end else begin
          fsm_next_s = ST_WAIT;
        end
      end
      ST_RESP: begin
        if (accept_s) begin
          fsm_next_s = ST_WAIT;
        end else if (bus.rsp_ready) begin
          fsm_next_s = ST_IDLE;
        end else begin
          fsm_next_s = ST_RESP;
        end
      end
      default: begin
        fsm_next_s = ST_IDLE;
      end
    endcase

    if (flush) begin
      next_state_s = ST_IDLE;
    end else begin
      next_state_s = fsm_next_s;
    end
  end

  // State, operand, wait-counter and response registers.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_r    <= ST_IDLE;
      cnt_r      <= CNT_W'(0);
      tag_r      <= TAG_W'(0);
      alu_a_r    <= DATA_W'(0);
      alu_b_r    <= DATA_W'(0);
      alu_op_r   <= OP_W'(0);
      rsp_data_r <= DATA_W'(0);
      rsp_zero_r <= 1'b0;
      rsp_tag_r  <= TAG_W'(0);
    end else begin
      state_r <= next_state_s;
      // Operands stay put between ops so the ALU keeps producing the same result.
      if (accept_s) begin
        alu_a_r  <= bus.req_a;
        alu_b_r  <= bus.req_b;
        alu_op_r <= bus.req_op;
        tag_r    <= bus.req_tag;
        cnt_r    <= CNT_W'(ALU_LAT);
      end else if ((state_r == ST_WAIT) && (cnt_r != CNT_W'(0))) begin
        cnt_r <= cnt_r - CNT_W'(1);
      end
      if (capture_s) begin
        rsp_data_r <= bus.alu_result;
        rsp_zero_r <= bus.alu_zero;
        rsp_tag_r  <= tag_r;
      end
    end
  end

  assign bus.req_ready = req_ready_s;
  assign bus.alu_a     = alu_a_r;
  assign bus.alu_b     = alu_b_r;
  assign bus.alu_op    = alu_op_r;
  assign bus.rsp_valid = (state_r == ST_RESP);
  assign bus.rsp_data  = rsp_data_r;
  assign bus.rsp_zero  = rsp_zero_r;
  assign bus.rsp_tag   = rsp_tag_r;
  assign busy          = (state_r != ST_IDLE);

endmodule
